led_pwm_multi: RTL

LED_PWM_MULTI -- requirements
Module: led_pwm_multi

---
 rtl/led_pwm_multi_if.sv | 30 +++
 rtl/led_pwm_multi.sv | 131 +++++++++++++
 2 files changed

// File: rtl/led_pwm_multi_if.sv
// Wishbone-style bus bundles for led_pwm_multi.
//
// led_pwm_multi_c_if : controller -> peripheral request
//   stb  strobe, a request is present this cycle
//   we   write enable (1 = write, 0 = read)
//   adr  register address
//   dat  write data
// led_pwm_multi_p_if : peripheral -> controller response
//   ack  one-cycle acknowledge
//   dat  read data, valid only while ack=1, otherwise 0
//
// Modports: master = controller side, slave = peripheral side.

interface led_pwm_multi_c_if;
    logic        stb;
    logic        we;
    logic [7:0]  adr;
    logic [15:0] dat;

    modport master (output stb, we, adr, dat);
    modport slave  (input  stb, we, adr, dat);
endinterface

interface led_pwm_multi_p_if;
    logic        ack;
    logic [15:0] dat;

    modport master (input  ack, dat);
    modport slave  (output ack, dat);
endinterface

// File: rtl/led_pwm_multi.sv
// Multi-channel LED PWM with per-channel target duty and an optional
// linear fade toward the target.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   wb_c  bus request (stb, we, adr, dat)
//   wb_p  bus response (ack, dat)
//   led   PWM outputs, bit i = channel i, active-high
//
// Register map: adr 0..CHANNELS-1 = TARGET[i] (BITS wide),
// adr CHANNELS = CTRL {FADE_DIV[7:2], FADE[1], EN[0]}, others read 0.

module led_pwm_multi #(
    parameter int CHANNELS = 3,
    parameter int BITS     = 8
) (
    input  logic                clk,
    input  logic                rst,
    led_pwm_multi_c_if.slave    wb_c,
    led_pwm_multi_p_if.slave    wb_p,
    output logic [CHANNELS-1:0] led
);

    // Last count value of a period (2^BITS-2); the period is 2^BITS-1
    // cycles so that a duty of all-ones keeps the output constantly high.
    localparam logic [BITS-1:0] CNT_LAST = {{(BITS-1){1'b1}}, 1'b0};

    logic [BITS-1:0] cnt;
    logic [5:0]      step_cnt;
    logic [BITS-1:0] target [CHANNELS];
    logic [BITS-1:0] cur    [CHANNELS];
    logic [7:0]      ctrl;
    logic            ack_q;
    logic [15:0]     dat_q;

    logic            en;
    logic            fade;
    logic [5:0]      fade_div;
    logic            wrap;
    logic            take;
    logic            wr;
    logic            step_hit;
    logic [15:0]     rd_data;
    logic            unused_dat;

    assign en       = ctrl[0];
    assign fade     = ctrl[1];
    assign fade_div = ctrl[7:2];

    // Bus handshake: a request is taken in any cycle with stb=1 and ack=0;
    // ack rises in the following cycle for exactly one cycle, carrying read
    // data, so a continuously held stb is serviced every other cycle.
    // Writes commit on the same edge that raises ack.
    assign take = wb_c.stb & ~ack_q;
    assign wr   = take & wb_c.we;
    assign wrap = (cnt == CNT_LAST);
    // A fade step happens on a wrap once the wrap counter has reached the divider.
    assign step_hit = wrap & fade & (step_cnt == fade_div);

    assign unused_dat = ^wb_c.dat;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wb_c.adr == 8'(i)) begin
                rd_data = 16'(target[i]);
            end
        end
        if (wb_c.adr == 8'(CHANNELS)) begin
            rd_data = {8'h00, ctrl};
        end
    end

    assign wb_p.ack = ack_q;
    assign wb_p.dat = dat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            step_cnt <= '0;
            ctrl     <= '0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            led      <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                target[i] <= '0;
                cur[i]    <= '0;
            end
        end else begin
            cnt   <= wrap ? '0 : cnt + BITS'(1);
            ack_q <= take;
            dat_q <= take ? rd_data : '0;

            if (wrap) begin
                if (!fade || step_hit) begin
                    step_cnt <= '0;
                end else begin
                    step_cnt <= step_cnt + 6'd1;
                end
            end

            if (wr && wb_c.adr == 8'(CHANNELS)) begin
                ctrl <= wb_c.dat[7:0];
            end

            for (int i = 0; i < CHANNELS; i++) begin
                led[i] <= (cnt < cur[i]) & en;
                // CUR only moves at the period boundary so a running
                // period is never cut short. A TARGET written in the wrap
                // cycle is not seen here because target[] updates on the
                // same edge.
                if (wrap) begin
                    if (!fade) begin
                        cur[i] <= target[i];
                    end else if (step_hit) begin
                        if (cur[i] < target[i]) begin
                            cur[i] <= cur[i] + BITS'(1);
                        end else if (cur[i] > target[i]) begin
                            cur[i] <= cur[i] - BITS'(1);
                        end
                    end
                end
                if (wr && wb_c.adr == 8'(i)) begin
                    target[i] <= wb_c.dat[BITS-1:0];
                end
            end
        end
    end

endmodule
